ghadi_setter: RTL and testbench

//  Button-driven front-end that writes the Aclock load interface. Debounces four push-buttons,

---
 rtl/ghadi_setter_if.sv | 33 +++
 rtl/ghadi_setter.sv | 195 +++++++++++++++++++
 tb/tb_ghadi_setter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/ghadi_setter_if.sv
// ghadi_setter_if
//   Signal bundle between the board-side driver (buttons, Aclock status) and
//   the ghadi_setter front-end.
//   master : drives buttons, tgt_alarm, Alarm, cur_*; observes load outputs
//   slave  : the setter itself
//   Buttons  : btn_mode, btn_inc, btn_set, btn_alarm (raw, asynchronous)
//   Status   : tgt_alarm (0 time / 1 alarm), Alarm (ringing), cur_H1/H0/M1/M0
//   Outputs  : H_in1/H_in0/M_in1/M_in0 (BCD), LD_time, LD_alarm, STOP_al,
//              AL_ON, edit_field
interface ghadi_setter_if;
  logic       btn_mode, btn_inc, btn_set, btn_alarm;
  logic       tgt_alarm, Alarm;
  logic [1:0] cur_H1;
  logic [3:0] cur_H0, cur_M1, cur_M0;
  logic [1:0] H_in1;
  logic [3:0] H_in0, M_in1, M_in0;
  logic       LD_time, LD_alarm, STOP_al, AL_ON;
  logic [1:0] edit_field;

  modport master (
    output btn_mode, btn_inc, btn_set, btn_alarm, tgt_alarm, Alarm,
           cur_H1, cur_H0, cur_M1, cur_M0,
    input  H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm, STOP_al, AL_ON,
           edit_field
  );

  modport slave (
    input  btn_mode, btn_inc, btn_set, btn_alarm, tgt_alarm, Alarm,
           cur_H1, cur_H0, cur_M1, cur_M0,
    output H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm, STOP_al, AL_ON,
           edit_field
  );
endinterface

// File: rtl/ghadi_setter.sv
// ghadi_setter
//   Button-driven editor that writes the Aclock load interface. Four buttons
//   are synchronised and debounced; an edit FSM (IDLE/HOUR/MIN/CONFIRM/LOAD)
//   edits BCD hour/minute registers and commits them with a LD_time or
//   LD_alarm strobe. Also owns AL_ON and the STOP_al strobe.
//   Ports:
//     clk    : rising-edge clock
//     reset  : asynchronous active-low reset
//     bus    : ghadi_setter_if.slave (buttons, status, BCD digits, strobes)
//   Optional feature macro: GHADI_SETTER_AUTOREPEAT_EN
//     When defined, holding btn_inc in HOUR/MIN repeats the increment every
//     REPEAT_CYCLES cycles after the first press event.
module ghadi_setter #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LOAD_CYCLES     = 2,
  parameter int REPEAT_CYCLES   = 5
) (
  input  logic           clk,
  input  logic           reset,
  ghadi_setter_if.slave  bus
);
  localparam int NB = 4;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LW = $clog2(LOAD_CYCLES + 1);

  localparam int B_MODE = 0, B_SET = 1, B_INC = 2, B_ALM = 3;

  localparam logic [2:0] S_IDLE = 3'd0, S_HOUR = 3'd1, S_MIN = 3'd2,
                         S_CONF = 3'd3, S_LOAD = 3'd4;

  // ---------------- debounce ----------------
  logic [NB-1:0]         w_raw;
  logic [NB-1:0]         r_s1, r_s2, r_stable, w_evt;
  logic [NB-1:0][DW-1:0] r_cnt;

  assign w_raw = {bus.btn_alarm, bus.btn_inc, bus.btn_set, bus.btn_mode};

  // Event fires in the cycle the accepted level is about to flip 0->1, so the
  // FSM consumes it on the same edge that updates r_stable.
  for (genvar g = 0; g < NB; g++) begin : g_evt
    assign w_evt[g] = r_s2[g] & ~r_stable[g] &
                      (r_cnt[g] == DW'(DEBOUNCE_CYCLES - 1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1     <= '0;
      r_s2     <= '0;
      r_stable <= '0;
      r_cnt    <= '0;
    end else begin
      r_s1 <= w_raw;
      r_s2 <= r_s1;
      for (int i = 0; i < NB; i++) begin
        if (r_s2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          r_stable[i] <= r_s2[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // ---------------- FSM state ----------------
  logic [2:0]    r_state;
  logic          r_tgt;
  logic [1:0]    r_h1;
  logic [3:0]    r_h0, r_m1, r_m0;
  logic [13:0]   r_shadow;
  logic [LW-1:0] r_ld_cnt, r_stop_cnt;
  logic          r_al_on;

  // ---------------- auto-repeat ----------------
  logic w_rep;
`ifdef GHADI_SETTER_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  logic [RW-1:0] r_rep;
  logic          w_hold;
  // Hold uses the synced raw level too, so repeats stop as soon as the
  // release is seen rather than after the release is debounced.
  assign w_hold = r_stable[B_INC] & r_s2[B_INC] &
                  ((r_state == S_HOUR) || (r_state == S_MIN));
  assign w_rep  = w_hold & (r_rep == RW'(REPEAT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                r_rep <= '0;
    else if (!w_hold || w_rep) r_rep <= '0;
    else                       r_rep <= r_rep + 1'b1;
  end
`else
  assign w_rep = 1'b0;
`endif

  // ---------------- event arbitration ----------------
  logic w_inc_any, w_any, w_stop, w_mode, w_set, w_inc, w_alm;
  assign w_inc_any = w_evt[B_INC] | w_rep;
  assign w_any     = w_evt[B_MODE] | w_evt[B_SET] | w_inc_any | w_evt[B_ALM];
  // While ringing every press becomes a stop request and nothing else.
  assign w_stop = bus.Alarm & w_any;
  assign w_mode = ~bus.Alarm & w_evt[B_MODE];
  assign w_set  = ~bus.Alarm & ~w_evt[B_MODE] & w_evt[B_SET];
  assign w_inc  = ~bus.Alarm & ~w_evt[B_MODE] & ~w_evt[B_SET] & w_inc_any;
  assign w_alm  = ~bus.Alarm & ~w_evt[B_MODE] & ~w_evt[B_SET] & ~w_inc_any &
                  w_evt[B_ALM];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_tgt      <= 1'b0;
      r_h1       <= '0;
      r_h0       <= '0;
      r_m1       <= '0;
      r_m0       <= '0;
      r_shadow   <= '0;
      r_ld_cnt   <= '0;
      r_stop_cnt <= '0;
      r_al_on    <= 1'b0;
    end else begin
      if (w_stop)               r_stop_cnt <= LW'(LOAD_CYCLES);
      else if (r_stop_cnt != 0) r_stop_cnt <= r_stop_cnt - 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_mode) begin
            r_state <= S_HOUR;
            r_tgt   <= bus.tgt_alarm;
            if (bus.tgt_alarm) begin
              {r_h1, r_h0, r_m1, r_m0} <= r_shadow;
            end else begin
              {r_h1, r_h0, r_m1, r_m0} <= {bus.cur_H1, bus.cur_H0,
                                           bus.cur_M1, bus.cur_M0};
            end
          end else if (w_alm) begin
            r_al_on <= ~r_al_on;
          end
        end
        S_HOUR: begin
          if (w_mode) begin
            r_state <= S_MIN;
          end else if (w_inc) begin
            if (r_h1 == 2'd2 && r_h0 == 4'd3) begin
              r_h1 <= '0;
              r_h0 <= '0;
            end else if (r_h0 == 4'd9) begin
              r_h1 <= r_h1 + 1'b1;
              r_h0 <= '0;
            end else begin
              r_h0 <= r_h0 + 1'b1;
            end
          end
        end
        S_MIN: begin
          if (w_mode) begin
            r_state <= S_CONF;
          end else if (w_inc) begin
            if (r_m0 == 4'd9) begin
              r_m0 <= '0;
              r_m1 <= (r_m1 == 4'd5) ? 4'd0 : r_m1 + 1'b1;
            end else begin
              r_m0 <= r_m0 + 1'b1;
            end
          end
        end
        S_CONF: begin
          if (w_mode) begin
            r_state <= S_IDLE;
          end else if (w_set) begin
            r_state  <= S_LOAD;
            r_ld_cnt <= LW'(LOAD_CYCLES - 1);
            if (r_tgt) r_shadow <= {r_h1, r_h0, r_m1, r_m0};
          end
        end
        S_LOAD: begin
          if (r_ld_cnt == 0) r_state  <= S_IDLE;
          else               r_ld_cnt <= r_ld_cnt - 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Strobes decode from state so an async reset drops them immediately.
  assign bus.H_in1      = r_h1;
  assign bus.H_in0      = r_h0;
  assign bus.M_in1      = r_m1;
  assign bus.M_in0      = r_m0;
  assign bus.LD_time    = (r_state == S_LOAD) & ~r_tgt;
  assign bus.LD_alarm   = (r_state == S_LOAD) &  r_tgt;
  assign bus.STOP_al    = (r_stop_cnt != 0);
  assign bus.AL_ON      = r_al_on;
  assign bus.edit_field = (r_state == S_LOAD) ? 2'd3 : r_state[1:0];
endmodule

// File: tb/tb_ghadi_setter.sv
// tb_ghadi_setter
//   Scoreboard bench for ghadi_setter. Expected load transactions are queued
//   when the commit press is driven; a monitor pops and compares them when a
//   load strobe completes. Hour/minute expectations come from an integer
//   model (mod 24 / mod 60) converted to BCD.
module tb_ghadi_setter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ghadi_setter_if bus();
  ghadi_setter #(.DEBOUNCE_CYCLES(4), .LOAD_CYCLES(2), .REPEAT_CYCLES(5)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  localparam int B_MODE = 0, B_SET = 1, B_INC = 2, B_ALM = 3;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  typedef struct packed { logic alarm; logic [13:0] dig; } ld_t;
  ld_t sb[$];

  function automatic logic [13:0] bcd(input int h, input int m);
    logic [1:0] a; logic [3:0] b, c, d;
    a = 2'(h / 10); b = 4'(h % 10); c = 4'(m / 10); d = 4'(m % 10);
    return {a, b, c, d};
  endfunction

  logic [13:0] dig;
  assign dig = {bus.H_in1, bus.H_in0, bus.M_in1, bus.M_in0};

  // load monitor
  int n_loads = 0;
  initial begin
    int   ld_w;
    logic ld_kind, ld_both, ld_stable;
    logic [13:0] ld_dig;
    ld_t  e;
    ld_w = 0; ld_kind = 0; ld_both = 0; ld_stable = 1; ld_dig = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        ld_w = 0;
      end else if (bus.LD_time || bus.LD_alarm) begin
        if (ld_w == 0) begin
          ld_kind = bus.LD_alarm; ld_dig = dig; ld_both = 0; ld_stable = 1;
        end
        if (bus.LD_time && bus.LD_alarm) ld_both = 1;
        if (dig !== ld_dig || bus.LD_alarm !== ld_kind) ld_stable = 0;
        ld_w++;
      end else if (ld_w != 0) begin
        n_loads++;
        if (sb.size() == 0) begin
          chk("ld_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("ld_kind", ld_kind, e.alarm);
          chk("ld_digits", ld_dig, e.dig);
        end
        chk("ld_width", ld_w, 2);
        chk("ld_stable", ld_stable, 1);
        chk("ld_excl", ld_both, 0);
        ld_w = 0;
      end
    end
  end

  // stop monitor
  int n_stops = 0;
  initial begin
    int st_w;
    st_w = 0;
    forever begin
      @(negedge clk);
      if (reset && bus.STOP_al) begin
        st_w++;
      end else if (st_w != 0) begin
        n_stops++;
        chk("stop_width", st_w, 2);
        st_w = 0;
      end
    end
  end

  task automatic set_btn(input int b, input logic v);
    case (b)
      B_MODE:  bus.btn_mode  = v;
      B_SET:   bus.btn_set   = v;
      B_INC:   bus.btn_inc   = v;
      default: bus.btn_alarm = v;
    endcase
  endtask

  task automatic press(input int b);
    set_btn(b, 1'b1);
    repeat (8) @(negedge clk);
    set_btn(b, 1'b0);
    repeat (8) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int h, m, sh_h, sh_m, wait_i;
    reset = 1'b0;
    bus.btn_mode = 0; bus.btn_inc = 0; bus.btn_set = 0; bus.btn_alarm = 0;
    bus.tgt_alarm = 0; bus.Alarm = 0;
    bus.cur_H1 = 2'd1; bus.cur_H0 = 4'd0; bus.cur_M1 = 4'd1; bus.cur_M0 = 4'd9;
    sh_h = 0; sh_m = 0;

    // 1. reset
    repeat (3) @(negedge clk);
    chk("rst_outs", {dig, bus.LD_time, bus.LD_alarm, bus.STOP_al, bus.AL_ON, bus.edit_field}, 0);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_rst", {dig, bus.LD_time, bus.LD_alarm, bus.STOP_al, bus.AL_ON, bus.edit_field}, 0);

    // 2. set time from 10:19
    h = 10; m = 19;
    press(B_MODE);
    chk("t_field_hour", bus.edit_field, 1);
    chk("t_load_cur", dig, bcd(h, m));
    for (int i = 0; i < 14; i++) begin press(B_INC); h = (h + 1) % 24; end
    chk("t_hour_wrap", dig, bcd(h, m));
    press(B_MODE);
    chk("t_field_min", bus.edit_field, 2);
    for (int i = 0; i < 41; i++) begin press(B_INC); m = (m + 1) % 60; end
    chk("t_min_wrap", dig, bcd(h, m));
    press(B_MODE);
    chk("t_field_conf", bus.edit_field, 3);
    sb.push_back('{1'b0, bcd(h, m)});
    press(B_SET);
    chk("t_field_idle", bus.edit_field, 0);
    chk("t_loads", n_loads, 1);

    // 3. set alarm
    bus.tgt_alarm = 1;
    press(B_MODE);
    chk("a_shadow_init", dig, bcd(sh_h, sh_m));
    h = sh_h; m = sh_m;
    press(B_MODE);
    for (int i = 0; i < 20; i++) begin press(B_INC); m = (m + 1) % 60; end
    chk("a_min", dig, bcd(h, m));
    press(B_MODE);
    sb.push_back('{1'b1, bcd(h, m)});
    sh_h = h; sh_m = m;
    press(B_SET);
    chk("a_loads", n_loads, 2);
    press(B_MODE);
    chk("a_shadow_kept", dig, bcd(sh_h, sh_m));
    chk("a_al_on", bus.AL_ON, 0);
    press(B_MODE); press(B_MODE); press(B_MODE);
    chk("abort_idle", bus.edit_field, 0);
    chk("abort_noload", n_loads, 2);

    // 4. AL_ON toggle, stop while ringing, priority
    bus.tgt_alarm = 0;
    press(B_ALM);
    chk("al_on_toggle", bus.AL_ON, 1);
    press(B_MODE);
    bus.Alarm = 1;
    press(B_INC);
    bus.Alarm = 0;
    chk("stop_count", n_stops, 1);
    chk("stop_no_inc", dig, bcd(10, 19));
    chk("stop_field", bus.edit_field, 1);
    set_btn(B_MODE, 1); set_btn(B_INC, 1);
    repeat (8) @(negedge clk);
    set_btn(B_MODE, 0); set_btn(B_INC, 0);
    repeat (8) @(negedge clk);
    chk("prio_field", bus.edit_field, 2);
    chk("prio_no_inc", dig, bcd(10, 19));
    press(B_MODE); press(B_MODE);
    chk("prio_idle", bus.edit_field, 0);

    // 5. bounce, glitch, latency, hold
    press(B_MODE);
    for (int i = 0; i < 20; i++) begin bus.btn_inc = i[0]; @(negedge clk); end
    bus.btn_inc = 0; repeat (8) @(negedge clk);
    bus.btn_inc = 1; repeat (3) @(negedge clk);
    bus.btn_inc = 0; repeat (10) @(negedge clk);
    chk("bounce_no_inc", dig, bcd(10, 19));
    bus.btn_inc = 1;
    repeat (5) @(negedge clk);
    chk("lat_before", dig, bcd(10, 19));
    @(negedge clk);
    chk("lat_at6", dig, bcd(11, 19));
    bus.btn_inc = 0; repeat (10) @(negedge clk);
    press(B_MODE);
    bus.btn_inc = 1; repeat (21) @(negedge clk);
    bus.btn_inc = 0; repeat (10) @(negedge clk);
`ifdef GHADI_SETTER_AUTOREPEAT_EN
    chk("held_inc", dig, bcd(11, 23));
`else
    chk("held_inc", dig, bcd(11, 20));
`endif
    press(B_MODE); press(B_MODE);
    chk("hold_idle", bus.edit_field, 0);

    // 6. reset during load
    press(B_MODE); press(B_MODE); press(B_MODE);
    bus.btn_set = 1;
    wait_i = 0;
    while (wait_i < 20 && !bus.LD_time) begin @(negedge clk); wait_i++; end
    chk("ld_seen", bus.LD_time, 1);
    #2 reset = 1'b0;
    #1;
    chk("rst_ld_drop", bus.LD_time, 0);
    chk("rst_ld_idle", bus.edit_field, 0);
    bus.btn_set = 0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ld_outs", {dig, bus.AL_ON}, 0);
    chk("rst_ld_noload", n_loads, 2);
    chk("sb_empty", sb.size(), 0);
    chk("stop_total", n_stops, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
